// File: rtl/priv_1_12_trap_ctrl.sv
// Purpose : M-mode trap controller; picks interrupt/exception at commit, owns mstatus/mepc/mcause/mtval/mip.
// Latency : intr/mret/redirect_pc combinational in the request cycle; CSR state updates on the next edge; mip lags lines by 1 cycle.
// Backpressure: pipe_stall or !insn_valid suppresses traps and MRET; nothing is latched, requests re-evaluated each cycle.
//
// Ports:
//   CLK, nRST                    clock, async active-low reset
//   insn_valid, pipe_stall, epc  commit-point status and PC
//   exc_req, exc_tval            per-cause exception requests and trap value
//   mret_req                     committing instruction is MRET
//   ext_int, tmr_int, sw_int     level interrupt lines
//   curr_priv                    current privilege level
//   mie_csr, mtvec               interrupt enables and trap vector
//   csr_wen, csr_addr, csr_wdata CSR write port
//   intr, mret, redirect_pc      trap/return pulses and target PC
//   mstatus_*, mepc, mcause, mtval, mip  CSR read values
module priv_1_12_trap_ctrl #(
  parameter logic [1:0] RESET_MPP = 2'b11,
  parameter int         XLEN      = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            insn_valid,
  input  logic            pipe_stall,
  input  logic [XLEN-1:0] epc,
  input  logic [15:0]     exc_req,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_req,
  input  logic            ext_int,
  input  logic            tmr_int,
  input  logic            sw_int,
  input  logic [1:0]      curr_priv,
  input  logic [XLEN-1:0] mie_csr,
  input  logic [XLEN-1:0] mtvec,
  input  logic            csr_wen,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            intr,
  output logic            mret,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic [1:0]      mstatus_mpp,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic [XLEN-1:0] mip
);

  // Causes whose trap value is meaningful; all others record mtval=0.
  localparam logic [15:0] TVAL_MASK = 16'hB0F7;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [1:0]      mpp_q, mpp_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [2:0]      mip_q, mip_d;   // {MEI, MTI, MSI}

  logic            gie;
  logic            pend_mei, pend_mti, pend_msi, int_pend;
  logic [4:0]      int_cause, exc_cause, cause;
  logic            exc_any;
  logic            commit, take, mret_take;
  logic [XLEN-1:0] vec_base;

  // Interrupts from below M-mode are always globally enabled.
  assign gie      = (curr_priv != 2'b11) | mie_q;
  assign pend_mei = mip_q[2] & mie_csr[11] & gie;
  assign pend_mti = mip_q[1] & mie_csr[7]  & gie;
  assign pend_msi = mip_q[0] & mie_csr[3]  & gie;
  assign int_pend = pend_mei | pend_mti | pend_msi;

  always_comb begin
    int_cause = 5'd7;
    if (pend_mei)      int_cause = 5'd11;
    else if (pend_msi) int_cause = 5'd3;
  end

  always_comb begin
    exc_any   = 1'b1;
    exc_cause = 5'd0;
    if      (exc_req[3])  exc_cause = 5'd3;
    else if (exc_req[12]) exc_cause = 5'd12;
    else if (exc_req[1])  exc_cause = 5'd1;
    else if (exc_req[2])  exc_cause = 5'd2;
    else if (exc_req[0])  exc_cause = 5'd0;
    else if (exc_req[8])  exc_cause = 5'd8;
    else if (exc_req[9])  exc_cause = 5'd9;
    else if (exc_req[11]) exc_cause = 5'd11;
    else if (exc_req[6])  exc_cause = 5'd6;
    else if (exc_req[4])  exc_cause = 5'd4;
    else if (exc_req[15]) exc_cause = 5'd15;
    else if (exc_req[13]) exc_cause = 5'd13;
    else if (exc_req[7])  exc_cause = 5'd7;
    else if (exc_req[5])  exc_cause = 5'd5;
    else                  exc_any   = 1'b0;
  end

  // Pulses are gated by nRST so nothing leaks out while reset is held.
  assign commit    = nRST & insn_valid & ~pipe_stall;
  assign take      = commit & (int_pend | exc_any);
  assign mret_take = commit & mret_req & ~take;
  assign cause     = int_pend ? int_cause : exc_cause;
  assign vec_base  = {mtvec[XLEN-1:2], 2'b00};

  assign intr = take;
  assign mret = mret_take;

  always_comb begin
    redirect_pc = '0;
    if (take) begin
      // Only interrupts honour vectored mode; modes 10/11 behave as direct.
      if (mtvec[1:0] == 2'b01 && int_pend) redirect_pc = vec_base + XLEN'({cause, 2'b00});
      else                                  redirect_pc = vec_base;
    end else if (mret_take) begin
      redirect_pc = mepc_q;
    end
  end

  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mpp_d    = mpp_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    mip_d    = {ext_int, tmr_int, sw_int};
    if (take) begin
      mepc_d   = {epc[XLEN-1:2], 2'b00};
      mcause_d = {int_pend, {(XLEN-6){1'b0}}, cause};
      mtval_d  = (!int_pend && TVAL_MASK[exc_cause[3:0]]) ? exc_tval : '0;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = curr_priv;
    end else if (mret_take) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
      mpp_d  = 2'b00;
    end else if (csr_wen) begin
      case (csr_addr)
        12'h300: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
          // Only M and U are implemented; anything else collapses to U.
          mpp_d  = (csr_wdata[12:11] == 2'b11) ? 2'b11 : 2'b00;
        end
        12'h341: mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
        12'h342: mcause_d = csr_wdata;
        12'h343: mtval_d  = csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mpp_q    <= RESET_MPP;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mip_q    <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mpp_q    <= mpp_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mip_q    <= mip_d;
    end
  end

  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;
  assign mstatus_mpp  = mpp_q;   // pre-update value during the MRET cycle
  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mtval        = mtval_q;

  always_comb begin
    mip     = '0;
    mip[11] = mip_q[2];
    mip[7]  = mip_q[1];
    mip[3]  = mip_q[0];
  end

  logic unused_ok;
  assign unused_ok = ^{mie_csr, epc[1:0]};

endmodule

// File: tb/tb_priv_1_12_trap_ctrl.sv
// Purpose : directed, table-driven bench for priv_1_12_trap_ctrl.
// Latency : outputs sampled on the falling edge (combinational) and 1 time unit after the rising edge (state).
// Backpressure: exercised via pipe_stall / insn_valid vectors.
module tb_priv_1_12_trap_ctrl;

  logic        CLK, nRST;
  logic        insn_valid, pipe_stall, mret_req;
  logic [31:0] epc, exc_tval, mie_csr, mtvec, csr_wdata;
  logic [15:0] exc_req;
  logic        ext_int, tmr_int, sw_int, csr_wen;
  logic [1:0]  curr_priv;
  logic [11:0] csr_addr;
  logic        intr, mret, mstatus_mie, mstatus_mpie;
  logic [1:0]  mstatus_mpp;
  logic [31:0] redirect_pc, mepc, mcause, mtval, mip;

  int checks = 0;
  int errors = 0;

  priv_1_12_trap_ctrl #(.RESET_MPP(2'b11), .XLEN(32)) dut (
    .CLK(CLK), .nRST(nRST), .insn_valid(insn_valid), .pipe_stall(pipe_stall),
    .epc(epc), .exc_req(exc_req), .exc_tval(exc_tval), .mret_req(mret_req),
    .ext_int(ext_int), .tmr_int(tmr_int), .sw_int(sw_int), .curr_priv(curr_priv),
    .mie_csr(mie_csr), .mtvec(mtvec), .csr_wen(csr_wen), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .intr(intr), .mret(mret), .redirect_pc(redirect_pc),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
    .mepc(mepc), .mcause(mcause), .mtval(mtval), .mip(mip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv, stall;
    logic [31:0] epc;
    logic [15:0] exc;
    logic [31:0] tval, mtvec;
    logic [1:0]  priv;
    logic        e_intr;
    logic [31:0] e_pc, e_mepc, e_mcause, e_mtval;
    logic [1:0]  e_mpp;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic iv, input logic stall, input logic [31:0] pc,
                              input logic [15:0] exc, input logic [31:0] tval,
                              input logic [31:0] tvec, input logic [1:0] priv,
                              input logic e_intr, input logic [31:0] e_pc,
                              input logic [31:0] e_mepc, input logic [31:0] e_mcause,
                              input logic [31:0] e_mtval, input logic [1:0] e_mpp);
    vec_t v;
    v.iv = iv; v.stall = stall; v.epc = pc; v.exc = exc; v.tval = tval; v.mtvec = tvec;
    v.priv = priv; v.e_intr = e_intr; v.e_pc = e_pc; v.e_mepc = e_mepc;
    v.e_mcause = e_mcause; v.e_mtval = e_mtval; v.e_mpp = e_mpp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_wen = 1'b0;
  endtask

  initial begin
    // iv stall epc exc tval mtvec priv | intr redirect mepc mcause mtval mpp
    tbl[0]  = mk(1'b1, 1'b0, 32'h100, 16'h0004, 32'hDEAD, 32'h8000_0001, 2'b00, 1'b1, 32'h8000_0000, 32'h100, 32'd2,  32'hDEAD, 2'b00);
    tbl[1]  = mk(1'b1, 1'b0, 32'h204, 16'h100A, 32'h1111, 32'h8000_0001, 2'b01, 1'b1, 32'h8000_0000, 32'h204, 32'd3,  32'h0,    2'b01);
    tbl[2]  = mk(1'b1, 1'b0, 32'h208, 16'h1006, 32'h2222, 32'h8000_0001, 2'b11, 1'b1, 32'h8000_0000, 32'h208, 32'd12, 32'h2222, 2'b11);
    tbl[3]  = mk(1'b1, 1'b0, 32'h20C, 16'h0101, 32'h3333, 32'h8000_0001, 2'b00, 1'b1, 32'h8000_0000, 32'h20C, 32'd0,  32'h3333, 2'b00);
    tbl[4]  = mk(1'b1, 1'b0, 32'h210, 16'h0B00, 32'h4444, 32'h8000_0001, 2'b00, 1'b1, 32'h8000_0000, 32'h210, 32'd8,  32'h0,    2'b00);
    tbl[5]  = mk(1'b1, 1'b0, 32'h214, 16'h4400, 32'h5555, 32'h8000_0001, 2'b01, 1'b0, 32'h0,         32'h210, 32'd8,  32'h0,    2'b00);
    tbl[6]  = mk(1'b1, 1'b0, 32'h218, 16'h8050, 32'h6666, 32'h8000_0001, 2'b11, 1'b1, 32'h8000_0000, 32'h218, 32'd6,  32'h6666, 2'b11);
    tbl[7]  = mk(1'b1, 1'b0, 32'h21C, 16'h20A0, 32'h7777, 32'h8000_0001, 2'b00, 1'b1, 32'h8000_0000, 32'h21C, 32'd13, 32'h7777, 2'b00);
    tbl[8]  = mk(1'b1, 1'b1, 32'h220, 16'h0020, 32'hAAAA, 32'h8000_0001, 2'b01, 1'b0, 32'h0,         32'h21C, 32'd13, 32'h7777, 2'b00);
    tbl[9]  = mk(1'b0, 1'b0, 32'h224, 16'h0020, 32'hBBBB, 32'h8000_0001, 2'b01, 1'b0, 32'h0,         32'h21C, 32'd13, 32'h7777, 2'b00);
    tbl[10] = mk(1'b1, 1'b0, 32'h303, 16'h0020, 32'h8888, 32'h8000_0001, 2'b11, 1'b1, 32'h8000_0000, 32'h300, 32'd5,  32'h8888, 2'b11);
    tbl[11] = mk(1'b1, 1'b0, 32'h400, 16'h0200, 32'h9999, 32'h0000_0400, 2'b00, 1'b1, 32'h400,       32'h400, 32'd9,  32'h0,    2'b00);
    tbl[12] = mk(1'b1, 1'b0, 32'h500, 16'h8000, 32'hAAAA, 32'h0000_0503, 2'b01, 1'b1, 32'h500,       32'h500, 32'd15, 32'hAAAA, 2'b01);

    // Reset with requests present: nothing may fire.
    nRST = 1'b0; insn_valid = 1'b1; pipe_stall = 1'b0; epc = 32'h40; exc_req = 16'h0004;
    exc_tval = 32'h0; mret_req = 1'b1; ext_int = 1'b1; tmr_int = 1'b1; sw_int = 1'b1;
    curr_priv = 2'b11; mie_csr = 32'h0; mtvec = 32'h8000_0001;
    csr_wen = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    #12;
    chk("reset intr", 32'(intr), 32'd0);
    chk("reset mret", 32'(mret), 32'd0);
    chk("reset mpp", 32'(mstatus_mpp), 32'd3);
    chk("reset mie", 32'(mstatus_mie), 32'd0);
    chk("reset mpie", 32'(mstatus_mpie), 32'd0);
    chk("reset mepc", mepc, 32'h0);
    chk("reset mcause", mcause, 32'h0);
    chk("reset mtval", mtval, 32'h0);
    chk("reset mip", mip, 32'h0);
    insn_valid = 1'b0; exc_req = 16'h0; mret_req = 1'b0;
    ext_int = 1'b0; tmr_int = 1'b0; sw_int = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      insn_valid = tbl[i].iv; pipe_stall = tbl[i].stall; epc = tbl[i].epc;
      exc_req = tbl[i].exc; exc_tval = tbl[i].tval; mtvec = tbl[i].mtvec; curr_priv = tbl[i].priv;
      @(negedge CLK);
      chk($sformatf("v%0d intr", i), 32'(intr), 32'(tbl[i].e_intr));
      chk($sformatf("v%0d mret", i), 32'(mret), 32'd0);
      chk($sformatf("v%0d redirect", i), redirect_pc, tbl[i].e_pc);
      tick();
      chk($sformatf("v%0d mepc", i), mepc, tbl[i].e_mepc);
      chk($sformatf("v%0d mcause", i), mcause, tbl[i].e_mcause);
      chk($sformatf("v%0d mtval", i), mtval, tbl[i].e_mtval);
      chk($sformatf("v%0d mpp", i), 32'(mstatus_mpp), 32'(tbl[i].e_mpp));
      chk($sformatf("v%0d mie", i), 32'(mstatus_mie), 32'd0);
    end
    insn_valid = 1'b0; pipe_stall = 1'b0; exc_req = 16'h0;

    // Timer interrupt, vectored, with one-cycle mip latency.
    csr_wr(12'h300, 32'h0000_1808);
    chk("csr mie set", 32'(mstatus_mie), 32'd1);
    chk("csr mpp 11", 32'(mstatus_mpp), 32'd3);
    tmr_int = 1'b1; mie_csr = 32'h888; mtvec = 32'h401; curr_priv = 2'b11;
    insn_valid = 1'b1; epc = 32'h600;
    @(negedge CLK);
    chk("mti latency intr", 32'(intr), 32'd0);
    tick();
    chk("mti mip", mip, 32'h80);
    @(negedge CLK);
    chk("mti intr", 32'(intr), 32'd1);
    chk("mti redirect", redirect_pc, 32'h41C);
    tick();
    chk("mti mcause", mcause, 32'h8000_0007);
    chk("mti mtval", mtval, 32'h0);
    chk("mti mepc", mepc, 32'h600);
    chk("mti mie", 32'(mstatus_mie), 32'd0);
    chk("mti mpie", 32'(mstatus_mpie), 32'd1);
    chk("mti mpp", 32'(mstatus_mpp), 32'd3);

    // All three interrupts plus exception 3: MEI wins.
    insn_valid = 1'b0; ext_int = 1'b1; sw_int = 1'b1;
    csr_wr(12'h300, 32'h0000_1808);
    insn_valid = 1'b1; exc_req = 16'h0008; epc = 32'h700; exc_tval = 32'hBEEF;
    @(negedge CLK);
    chk("mei intr", 32'(intr), 32'd1);
    chk("mei redirect", redirect_pc, 32'h42C);
    tick();
    chk("mei mcause", mcause, 32'h8000_000B);
    chk("mei mtval", mtval, 32'h0);
    chk("mei mepc", mepc, 32'h700);

    // ecall from U with interrupts masked in mie: exception taken.
    exc_req = 16'h0100; mie_csr = 32'h0; curr_priv = 2'b00; epc = 32'h704;
    @(negedge CLK);
    chk("ecall intr", 32'(intr), 32'd1);
    chk("ecall redirect", redirect_pc, 32'h400);
    tick();
    chk("ecall mcause", mcause, 32'd8);
    chk("ecall mpp", 32'(mstatus_mpp), 32'd0);
    insn_valid = 1'b0; exc_req = 16'h0; curr_priv = 2'b11;
    ext_int = 1'b0; tmr_int = 1'b0; sw_int = 1'b0;

    // MRET; a concurrent mepc write must be dropped.
    csr_wr(12'h300, 32'h0000_1880);
    csr_wr(12'h341, 32'h0000_0203);
    chk("mepc write align", mepc, 32'h200);
    insn_valid = 1'b1; mret_req = 1'b1;
    csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h999;
    @(negedge CLK);
    chk("mret pulse", 32'(mret), 32'd1);
    chk("mret intr", 32'(intr), 32'd0);
    chk("mret redirect", redirect_pc, 32'h200);
    chk("mret mpp during", 32'(mstatus_mpp), 32'd3);
    tick();
    csr_wen = 1'b0;
    chk("mret mie", 32'(mstatus_mie), 32'd1);
    chk("mret mpie", 32'(mstatus_mpie), 32'd1);
    chk("mret mpp after", 32'(mstatus_mpp), 32'd0);
    chk("mret csr dropped", mepc, 32'h200);

    // MRET together with exception 0: trap wins.
    exc_req = 16'h0001; epc = 32'h800; exc_tval = 32'h77;
    @(negedge CLK);
    chk("trap+mret intr", 32'(intr), 32'd1);
    chk("trap+mret mret", 32'(mret), 32'd0);
    chk("trap+mret redirect", redirect_pc, 32'h400);
    tick();
    chk("trap+mret mcause", mcause, 32'd0);
    chk("trap+mret mtval", mtval, 32'h77);
    chk("trap+mret mie", 32'(mstatus_mie), 32'd0);
    chk("trap+mret mpie", 32'(mstatus_mpie), 32'd1);

    // Stalled MRET: nothing fires, state holds.
    exc_req = 16'h0; pipe_stall = 1'b1;
    @(negedge CLK);
    chk("stall mret", 32'(mret), 32'd0);
    chk("stall intr", 32'(intr), 32'd0);
    tick();
    chk("stall mie", 32'(mstatus_mie), 32'd0);
    chk("stall mpie", 32'(mstatus_mpie), 32'd1);
    chk("stall mepc", mepc, 32'h800);
    mret_req = 1'b0; pipe_stall = 1'b0;

    // Trap plus mcause write: trap wins.
    exc_req = 16'h0004; epc = 32'h900; exc_tval = 32'h0;
    csr_wen = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
    tick();
    csr_wen = 1'b0;
    chk("trap+csr mcause", mcause, 32'd2);
    chk("trap+csr mepc", mepc, 32'h900);
    insn_valid = 1'b0; exc_req = 16'h0;
    csr_wr(12'h343, 32'h1234);
    chk("mtval write", mtval, 32'h1234);
    csr_wr(12'h344, 32'hFFFF);
    chk("mip write ignored", mip, 32'h0);
    insn_valid = 1'b1; pipe_stall = 1'b1; exc_req = 16'h0004;
    csr_wr(12'h342, 32'h55);
    chk("stalled csr write", mcause, 32'h55);
    pipe_stall = 1'b0; insn_valid = 1'b0; exc_req = 16'h0;

    // mstatus WARL on MPP.
    csr_wr(12'h300, 32'h0000_1880);
    chk("warl mpp 11", 32'(mstatus_mpp), 32'd3);
    csr_wr(12'h300, 32'h0000_1000);
    chk("warl mpp 10", 32'(mstatus_mpp), 32'd0);
    chk("warl mpie", 32'(mstatus_mpie), 32'd0);

    // Reset asserted while a trap is being requested.
    csr_wr(12'h300, 32'h0000_0080);
    insn_valid = 1'b1; exc_req = 16'h0004; epc = 32'hA00; curr_priv = 2'b00;
    @(negedge CLK);
    chk("midrst pre intr", 32'(intr), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst intr", 32'(intr), 32'd0);
    chk("midrst mepc", mepc, 32'h0);
    chk("midrst mcause", mcause, 32'h0);
    chk("midrst mtval", mtval, 32'h0);
    chk("midrst mpie", 32'(mstatus_mpie), 32'd0);
    chk("midrst mpp", 32'(mstatus_mpp), 32'd3);
    tick();
    chk("midrst held mepc", mepc, 32'h0);
    chk("midrst held intr", 32'(intr), 32'd0);
    insn_valid = 1'b0; exc_req = 16'h0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priv_1_12_trap_ctrl.md
Name: priv_1_12_trap_ctrl

Overview:
Trap controller for the 1.12 privilege unit. It sits directly upstream of the privilege-mode switcher. Each cycle it decides whether the instruction at the commit point takes an interrupt or a synchronous exception. It owns the M-mode trap state (mstatus MIE/MPIE/MPP, mepc, mcause, mtval, mip) and produces the intr/mret pulses, trap/return PC, and mstatus.mpp that the mode switcher consumes.

Parameters:
RESET_MPP, 2'b11, reset value of mstatus.MPP (M-mode)
XLEN, 32, data/address width

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
insn_valid  in  1  an instruction occupies the commit point this cycle
pipe_stall  in  1  commit point is stalled; no trap or mret may be taken
epc  in  XLEN  PC of the committing instruction
exc_req  in  16  one bit per exception cause code 0..15
exc_tval  in  XLEN  faulting address or instruction bits
mret_req  in  1  committing instruction is MRET
ext_int, tmr_int, sw_int  in  1 each  level interrupt lines (MEI, MTI, MSI)
curr_priv  in  2  current privilege level from the mode switcher
mie_csr  in  XLEN  mie register (enable bits 11, 7, 3 used)
mtvec  in  XLEN  trap vector base[31:2], mode[1:0]
csr_wen  in  1  CSR write strobe
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  CSR write data
intr  out  1  trap taken this cycle (feeds the mode switcher)
mret  out  1  mret taken this cycle
redirect_pc  out  XLEN  trap vector when intr; mepc when mret; else 0
mstatus_mie, mstatus_mpie  out  1 each  stack bits
mstatus_mpp  out  2  previous privilege
mepc, mcause, mtval, mip  out  XLEN each  CSR read values

Behaviour:
- Reset (async): MIE=0, MPIE=0, MPP=RESET_MPP, mepc=0, mcause=0, mtval=0, mip=0. intr=0 and mret=0 while nRST is low.
- mip: bits 11, 7, 3 are registered from ext_int, tmr_int, sw_int every cycle (1-cycle latency). All other bits read 0.
- Global enable: gie = (curr_priv != 2'b11) | MIE.
- Pending interrupt: mip & mie_csr & {gie}. Priority MEI(11) > MSI(3) > MTI(7).
- Exception priority over exc_req: 3 > 12 > 1 > 2 > 0 > 8 > 9 > 11 > 6 > 4 > 15 > 13 > 7 > 5. Cause codes 10 and 14 are ignored.
- take = insn_valid & ~pipe_stall & (int_pend | exc_any). Interrupt beats exception.
- intr = take, combinational, in the same cycle as the request.
- mret = insn_valid & ~pipe_stall & mret_req & ~take. Trap beats MRET.
- redirect_pc on a trap:
  - mtvec[1:0]==01 and interrupt: {mtvec[31:2],2'b00} + 4*cause.
  - Otherwise: {mtvec[31:2],2'b00}. Modes 10 and 11 are treated as direct.
- redirect_pc on mret: mepc.
- On the clock edge where intr=1:
  - mepc <= {epc[31:2],2'b00}.
  - mcause <= {is_int, 26'b0, cause[4:0]}.
  - mtval <= exc_tval for causes 0, 1, 2, 4, 5, 6, 7, 12, 13, 15; otherwise 0. Always 0 for interrupts.
  - MPIE <= MIE; MIE <= 0; MPP <= curr_priv.
- On the clock edge where mret=1: MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
- mstatus_mpp is the pre-update value during the mret cycle, so the mode switcher samples the return level correctly.
- CSR writes (csr_wen, no intr/mret that cycle):
  - 0x300 mstatus: bit 3 -> MIE, bit 7 -> MPIE, bits 12:11 -> MPP. An MPP write of 01 or 10 stores 00 (WARL).
  - 0x341 mepc: bits 1:0 forced to 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - mip writes are ignored.
- Simultaneous events:
  - Trap + CSR write: trap update wins, the write is dropped.
  - MRET + CSR write: MRET wins.
- pipe_stall=1 or insn_valid=0: no state change except mip sampling and CSR writes. Pending requests are re-evaluated every cycle; nothing is latched.
- Reset asserted mid-trap: all state returns to reset values immediately. There is no partial update.

Test Plan:
- Reset -> mstatus_mpp=11, MIE=0, mepc=0, mcause=0, intr=0, mret=0.
- exc_req[2]=1, epc=0x100, exc_tval=0xDEAD, mtvec=0x8000_0001, insn_valid -> intr=1 same cycle, redirect_pc=0x8000_0000. Next cycle: mepc=0x100, mcause=2, mtval=0xDEAD, MIE=0, MPP=prior priv.
- MIE=1, mie_csr[7]=1, tmr_int=1, curr_priv=11, mtvec=0x400 with mode 01 -> intr=1 in the second cycle (mip latency), redirect_pc=0x41C, mcause=0x8000_0007, mtval=0.
- ext_int, sw_int and exc_req[3] all asserted with interrupts enabled -> mcause=0x8000_000B. ecall from U-mode with MIE=0 and mip set -> exception taken, mcause=8, MPP=00.
- MPIE=1, MPP=00, mepc=0x200, mret_req -> mret=1, redirect_pc=0x200, mstatus_mpp=00 during the pulse. Next cycle: MIE=1, MPIE=1, MPP=00.
- mret_req and exc_req[0] together, plus pipe_stall cases -> trap wins and mret=0. With pipe_stall=1, neither event fires and state holds. A csr_wen to 0x300 with MPP=10 reads back MPP=00.
